// File: rtl/pipeline_alu_rv.sv
// pipeline_alu_rv: valid/ready pipelined ALU with bubble collapsing, flush and occupancy count
//   i_clk, i_rst_n       : clock and asynchronous active-low reset
//   i_a, i_b, i_opcode   : operands and operation select (S0 captures them)
//   i_valid / o_ready    : input handshake
//   i_flush              : drops every in-flight op at the next edge
//   o_result/o_zero/o_cf/o_ovf/o_valid : last stage contents
//   i_ready              : consumer accepts the output
//   o_occupancy          : registered count of valid stages
module pipeline_alu_rv #(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [WIDTH-1:0]             i_a,
  input  logic [WIDTH-1:0]             i_b,
  input  logic [2:0]                   i_opcode,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic                         i_flush,
  output logic [WIDTH-1:0]             o_result,
  output logic                         o_zero,
  output logic                         o_cf,
  output logic                         o_ovf,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [$clog2(LATENCY+1)-1:0] o_occupancy
);
  localparam int SW = $clog2(WIDTH);
  localparam int OW = $clog2(LATENCY+1);
  logic [LATENCY-1:0] v_q, v_d, ld;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   res_q [1:LATENCY-1];
  logic [LATENCY-1:1] z_q, c_q, ov_q;
  logic [OW-1:0]      occ_q, occ_d;
  logic [WIDTH-1:0]   alu_res;
  logic [WIDTH:0]     wide;
  logic [SW-1:0]      sh;
  logic               alu_c, alu_ov, accept;
  // a stage loads when empty or when the stage after it loads, so bubbles never block
  always_comb begin
    ld[LATENCY-1] = ~v_q[LATENCY-1] | i_ready;
    for (int k = LATENCY-2; k >= 0; k--) ld[k] = ~v_q[k] | ld[k+1];
  end
  assign o_ready = ld[0] & ~i_flush;
  assign accept  = i_valid & o_ready;
  always_comb begin
    v_d   = '0;
    occ_d = '0;
    if (!i_flush) begin
      v_d[0] = ld[0] ? accept : v_q[0];
      for (int k = 1; k < LATENCY; k++) v_d[k] = ld[k] ? v_q[k-1] : v_q[k];
    end
    for (int k = 0; k < LATENCY; k++) occ_d = occ_d + OW'(v_d[k]);
  end
  assign sh = b_q[SW-1:0];
  // shifts run one bit wider so the last bit shifted out lands in the extra bit
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_ov  = 1'b0;
    wide    = '0;
    case (op_q)
      3'b000: begin
        wide             = {1'b0, a_q} + {1'b0, b_q};
        {alu_c, alu_res} = wide;
        alu_ov           = (a_q[WIDTH-1] == b_q[WIDTH-1]) & (alu_res[WIDTH-1] != a_q[WIDTH-1]);
      end
      3'b001: begin
        wide             = {1'b0, a_q} - {1'b0, b_q};
        {alu_c, alu_res} = wide;
        alu_ov           = (a_q[WIDTH-1] != b_q[WIDTH-1]) & (alu_res[WIDTH-1] != a_q[WIDTH-1]);
      end
      3'b010: alu_res = a_q & b_q;
      3'b011: alu_res = a_q | b_q;
      3'b100: alu_res = a_q ^ b_q;
      3'b101: begin
        wide             = {1'b0, a_q} << sh;
        {alu_c, alu_res} = wide;
      end
      3'b110: begin
        wide             = {a_q, 1'b0} >> sh;
        {alu_res, alu_c} = wide;
      end
      default: alu_res = a_q;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v_q   <= '0;
      occ_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      z_q   <= '0;
      c_q   <= '0;
      ov_q  <= '0;
      for (int k = 1; k < LATENCY; k++) res_q[k] <= '0;
    end else begin
      v_q   <= v_d;
      occ_q <= occ_d;
      if (ld[0]) begin
        a_q  <= i_a;
        b_q  <= i_b;
        op_q <= i_opcode;
      end
      if (ld[1]) begin
        res_q[1] <= alu_res;
        z_q[1]   <= ~|alu_res;
        c_q[1]   <= alu_c;
        ov_q[1]  <= alu_ov;
      end
      for (int k = 2; k < LATENCY; k++) begin
        if (ld[k]) begin
          res_q[k] <= res_q[k-1];
          z_q[k]   <= z_q[k-1];
          c_q[k]   <= c_q[k-1];
          ov_q[k]  <= ov_q[k-1];
        end
      end
    end
  end
  assign o_result    = res_q[LATENCY-1];
  assign o_zero      = z_q[LATENCY-1];
  assign o_cf        = c_q[LATENCY-1];
  assign o_ovf       = ov_q[LATENCY-1];
  assign o_valid     = v_q[LATENCY-1];
  assign o_occupancy = occ_q;
endmodule

// File: tb/tb_pipeline_alu_rv.sv
// tb_pipeline_alu_rv: random and directed stimulus on LATENCY=2 and LATENCY=4 instances against a position-queue model
module tb_pipeline_alu_rv;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [7:0] a, b;
  logic [2:0] op;
  logic vin, rin, flush;
  logic       rdy [2];
  logic [7:0] res [2];
  logic       zf [2], cf [2], of [2], vout [2];
  logic [1:0] occ2;
  logic [2:0] occ4;
  pipeline_alu_rv #(.WIDTH(8), .LATENCY(2)) u_l2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_a(a), .i_b(b), .i_opcode(op), .i_valid(vin),
    .o_ready(rdy[0]), .i_flush(flush), .o_result(res[0]), .o_zero(zf[0]), .o_cf(cf[0]),
    .o_ovf(of[0]), .o_valid(vout[0]), .i_ready(rin), .o_occupancy(occ2));
  pipeline_alu_rv #(.WIDTH(8), .LATENCY(4)) u_l4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_a(a), .i_b(b), .i_opcode(op), .i_valid(vin),
    .o_ready(rdy[1]), .i_flush(flush), .o_result(res[1]), .o_zero(zf[1]), .o_cf(cf[1]),
    .o_ovf(of[1]), .o_valid(vout[1]), .i_ready(rin), .o_occupancy(occ4));
  typedef struct {logic [7:0] a; logic [7:0] b; logic [2:0] op; int pos;} ent_t;
  ent_t mq [2][4];
  int   mn [2];
  int   lat [2] = '{2, 4};
  int   n_chk = 0;
  int   n_pass = 0;
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask
  function automatic logic [10:0] ref_alu(input logic [7:0] x, input logic [7:0] y, input logic [2:0] o);
    int ua, ub, sa, sb, s, r;
    bit c, v;
    ua = x; ub = y; sa = $signed(x); sb = $signed(y); s = y % 8; r = 0; c = 0; v = 0;
    case (o)
      0: begin r = ua + ub; c = r > 255; v = (sa + sb > 127) || (sa + sb < -128); end
      1: begin r = ua - ub; c = ua < ub; v = (sa - sb > 127) || (sa - sb < -128); end
      2: r = ua & ub;
      3: r = ua | ub;
      4: r = ua ^ ub;
      5: begin r = ua << s; c = (s != 0) && (((ua >> (8 - s)) & 1) == 1); end
      6: begin r = ua >> s; c = (s != 0) && (((ua >> (s - 1)) & 1) == 1); end
      default: r = ua;
    endcase
    r = r & 255;
    return {v, c, r == 0, r[7:0]};
  endfunction
  // each entry moves one slot forward per edge unless it would run into the entry ahead
  function automatic int tail_pos(input int m);
    int prev, np;
    prev = lat[m];
    for (int i = 0; i < mn[m]; i++) begin
      if (i == 0 && mq[m][0].pos == lat[m] - 1 && rin) continue;
      np = mq[m][i].pos + 1;
      prev = (np < prev - 1) ? np : prev - 1;
    end
    return prev;
  endfunction
  task automatic mstep(input int m, input bit acc);
    ent_t t [4];
    int   n, prev, np;
    n = 0;
    prev = lat[m];
    if (flush) begin
      mn[m] = 0;
      return;
    end
    for (int i = 0; i < mn[m]; i++) begin
      if (i == 0 && mq[m][0].pos == lat[m] - 1 && rin) continue;
      np = mq[m][i].pos + 1;
      np = (np < prev - 1) ? np : prev - 1;
      t[n] = mq[m][i];
      t[n].pos = np;
      prev = np;
      n++;
    end
    if (acc) begin
      t[n].a = a; t[n].b = b; t[n].op = op; t[n].pos = 0;
      n++;
    end
    for (int i = 0; i < n; i++) mq[m][i] = t[i];
    mn[m] = n;
  endtask
  task automatic check_out(input int m);
    logic [10:0] e;
    bit mv;
    mv = mn[m] > 0 && mq[m][0].pos == lat[m] - 1;
    chk($sformatf("L%0d_valid", lat[m]), vout[m], mv);
    chk($sformatf("L%0d_occ", lat[m]), m == 0 ? {1'b0, occ2} : occ4, mn[m]);
    if (mv) begin
      e = ref_alu(mq[m][0].a, mq[m][0].b, mq[m][0].op);
      chk($sformatf("L%0d_result", lat[m]), res[m], e[7:0]);
      chk($sformatf("L%0d_zero", lat[m]), zf[m], e[8]);
      chk($sformatf("L%0d_cf", lat[m]), cf[m], e[9]);
      chk($sformatf("L%0d_ovf", lat[m]), of[m], e[10]);
    end
  endtask
  task automatic cycle(input bit v, input bit r, input bit f, input logic [7:0] x, input logic [7:0] y, input logic [2:0] o);
    bit acc [2];
    bit mr;
    vin = v; rin = r; flush = f; a = x; b = y; op = o;
    #1;
    for (int m = 0; m < 2; m++) begin
      mr = !f && tail_pos(m) > 0;
      acc[m] = v && mr;
      chk($sformatf("L%0d_ready", lat[m]), rdy[m], mr);
    end
    @(posedge clk);
    for (int m = 0; m < 2; m++) mstep(m, acc[m]);
    @(negedge clk);
    for (int m = 0; m < 2; m++) check_out(m);
  endtask
  task automatic check_zero(input string tag);
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("%s_L%0d_valid", tag, lat[m]), vout[m], 0);
      chk($sformatf("%s_L%0d_result", tag, lat[m]), res[m], 0);
      chk($sformatf("%s_L%0d_zero", tag, lat[m]), zf[m], 0);
      chk($sformatf("%s_L%0d_cf", tag, lat[m]), cf[m], 0);
      chk($sformatf("%s_L%0d_ovf", tag, lat[m]), of[m], 0);
    end
    chk($sformatf("%s_occ2", tag), occ2, 0);
    chk($sformatf("%s_occ4", tag), occ4, 0);
  endtask
  task automatic directed(input string tag, input logic [7:0] x, input logic [7:0] y, input logic [2:0] o,
                          input logic [7:0] er, input bit ez, input bit ec, input bit eo);
    repeat (4) cycle(0, 1, 0, 8'h00, 8'h00, 3'b000);
    cycle(1, 1, 0, x, y, o);
    chk({tag, "_early"}, vout[0], 0);
    cycle(0, 1, 0, 8'h00, 8'h00, 3'b000);
    chk({tag, "_valid"}, vout[0], 1);
    chk({tag, "_result"}, res[0], er);
    chk({tag, "_zero"}, zf[0], ez);
    chk({tag, "_cf"}, cf[0], ec);
    chk({tag, "_ovf"}, of[0], eo);
    cycle(0, 1, 0, 8'h00, 8'h00, 3'b000);
    chk({tag, "_once"}, vout[0], 0);
  endtask
  function automatic logic [7:0] pick();
    logic [7:0] edge_vals [5] = '{8'h00, 8'hff, 8'h80, 8'h7f, 8'h01};
    return ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 4)] : 8'($urandom);
  endfunction
  initial begin
    vin = 0; rin = 0; flush = 0; a = 0; b = 0; op = 0;
    mn[0] = 0; mn[1] = 0;
    repeat (2) @(negedge clk);
    #1 check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    directed("add_ff_01", 8'hff, 8'h01, 3'b000, 8'h00, 1, 1, 0);
    directed("sub_80_01", 8'h80, 8'h01, 3'b001, 8'h7f, 0, 0, 1);
    directed("sub_00_01", 8'h00, 8'h01, 3'b001, 8'hff, 0, 1, 0);
    directed("shl_81_1", 8'h81, 8'h01, 3'b101, 8'h02, 0, 1, 0);
    directed("shr_01_1", 8'h01, 8'h01, 3'b110, 8'h00, 1, 1, 0);
    for (int i = 0; i < 10; i++)
      cycle(i < 5, !(i >= 2 && i < 5), 0, 8'(i * 17 + 3), 8'(i + 1), 3'(i));
    repeat (3) cycle(1, 0, 0, pick(), pick(), 3'($urandom));
    cycle(1, 0, 1, 8'h11, 8'h22, 3'b000);
    for (int i = 0; i < 6; i++) cycle(i == 0, 1, 0, 8'h40, 8'h40, 3'b000);
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0,
            pick(), pick(), 3'($urandom));
      if (i == 300) begin
        #2 rst_n = 1'b0;
        #1 check_zero("midreset");
        mn[0] = 0; mn[1] = 0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
